// File: rtl/ccd_line_sequencer.sv
// ccd_line_sequencer
//   Linear-CCD timing generator with serial ADC readout. All timing advances on
//   a tick enable derived from i_clk_160M (period i_div+1 clocks); no derived
//   clocks. Each line is a transfer phase followed by N_PIX+1 pixel slots; the
//   word shifted in during slot p belongs to pixel p-1, so slot 0 yields nothing.
//
// Ports
//   i_clk_160M, i_nrst          clock, asynchronous active-low reset
//   i_en                        line request (level)
//   i_continuous                restart back-to-back while i_en stays high
//   i_cal_mode                  flag every pixel valid
//   i_div[DIV_W]                tick period minus one, in clocks
//   o_ccd_p1/p2/sh/rs/cp        CCD phase, transfer, reset and clamp clocks
//   o_adc_cs, o_adc_sclk        ADC convert/select and serial clock
//   i_adc_sdo                   ADC serial data, MSB first
//   o_pix_valid/data/index      pixel word strobe, word and pixel number
//   o_line_start, o_line_done   one-clock line boundary pulses
//   o_busy                      high from transfer start to line end
module ccd_line_sequencer #(
  parameter int N_PIX       = 2088,
  parameter int ADC_BITS    = 16,
  parameter int SLOT_TICKS  = 48,
  parameter int CS_TICKS    = 8,
  parameter int SH_TICKS    = 80,
  parameter int VALID_FIRST = 32,
  parameter int VALID_LAST  = 2079,
  parameter int DIV_W       = 8
) (
  input  logic                i_clk_160M,
  input  logic                i_nrst,
  input  logic                i_en,
  input  logic                i_continuous,
  input  logic                i_cal_mode,
  input  logic [DIV_W-1:0]    i_div,
  output logic                o_ccd_p1,
  output logic                o_ccd_p2,
  output logic                o_ccd_sh,
  output logic                o_ccd_rs,
  output logic                o_ccd_cp,
  output logic                o_adc_cs,
  output logic                o_adc_sclk,
  input  logic                i_adc_sdo,
  output logic                o_pix_valid,
  output logic [ADC_BITS-1:0] o_pix_data,
  output logic [13:0]         o_pix_index,
  output logic                o_line_start,
  output logic                o_line_done,
  output logic                o_busy
);

  localparam int T_MAX = (SH_TICKS > SLOT_TICKS) ? SH_TICKS : SLOT_TICKS;
  localparam int T_W   = (T_MAX > 2) ? $clog2(T_MAX) : 1;

  localparam logic [T_W-1:0] L_ONE       = T_W'(1);
  localparam logic [T_W-1:0] L_TWO       = T_W'(2);
  localparam logic [T_W-1:0] L_THREE     = T_W'(3);
  localparam logic [T_W-1:0] L_FOUR      = T_W'(4);
  localparam logic [T_W-1:0] L_FIVE      = T_W'(5);
  localparam logic [T_W-1:0] L_SH_ON     = T_W'(SH_TICKS / 4);
  localparam logic [T_W-1:0] L_SH_OFF    = T_W'(3 * SH_TICKS / 4 - 1);
  localparam logic [T_W-1:0] L_SH_LAST   = T_W'(SH_TICKS - 1);
  localparam logic [T_W-1:0] L_SLOT_LAST = T_W'(SLOT_TICKS - 1);
  localparam logic [T_W-1:0] L_HALF      = T_W'(SLOT_TICKS / 2);
  localparam logic [T_W-1:0] L_CS        = T_W'(CS_TICKS);
  localparam logic [T_W-1:0] L_SCLK_END  = T_W'(CS_TICKS + 2 * ADC_BITS);
  localparam logic [13:0]    L_NPIX      = 14'(N_PIX);
  localparam logic [13:0]    L_VFIRST    = 14'(VALID_FIRST);
  localparam logic [13:0]    L_VLAST     = 14'(VALID_LAST);

  // RESTART is the single idle-looking tick between back-to-back lines; busy
  // stays high through it.
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_PIX, S_RESTART} state_t;

  state_t                r_state, w_state_next;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [T_W-1:0]        r_tcnt, w_tcnt_next;
  logic [13:0]           r_slot, w_slot_next;
  logic [ADC_BITS-1:0]   r_shift;
  logic                  r_pix_valid, r_line_start, r_line_done, r_busy;
  logic [ADC_BITS-1:0]   r_pix_data;
  logic [13:0]           r_pix_index;

  logic                  w_tick;
  logic                  w_start, w_end, w_word;
  logic                  w_p1, w_sh, w_rs, w_cp, w_cs, w_sclk;
  logic [T_W-1:0]        w_sclk_off;
  logic [13:0]           w_idx;
  logic                  w_in_win;

  // Comparing against the live divider value means a new div is honoured at
  // the next wrap of the counter.
  assign w_tick = (r_div_cnt >= i_div);

  always_ff @(posedge i_clk_160M or negedge i_nrst) begin
    if (!i_nrst)     r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end

  always_ff @(posedge i_clk_160M or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_slot  <= '0;
    end else if (w_tick) begin
      r_state <= w_state_next;
      r_tcnt  <= w_tcnt_next;
      r_slot  <= w_slot_next;
    end
  end

  // sclk is high on even offsets inside the serial window, low on odd ones.
  assign w_sclk_off = r_tcnt - L_CS;
  assign w_idx      = r_slot - 14'd1;
  assign w_in_win   = (w_idx >= L_VFIRST) && (w_idx <= L_VLAST);

  always_comb begin
    w_state_next = r_state;
    w_tcnt_next  = r_tcnt;
    w_slot_next  = r_slot;
    w_start      = 1'b0;
    w_end        = 1'b0;
    w_word       = 1'b0;
    w_p1         = 1'b1;
    w_sh         = 1'b0;
    w_rs         = 1'b0;
    w_cp         = 1'b0;
    w_cs         = 1'b0;
    w_sclk       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_state_next = S_XFER;
          w_tcnt_next  = '0;
          w_start      = 1'b1;
        end
      end
      S_RESTART: begin
        w_state_next = S_XFER;
        w_tcnt_next  = '0;
        w_start      = 1'b1;
      end
      S_XFER: begin
        w_rs = (r_tcnt >= L_ONE) && (r_tcnt <= L_TWO);
        w_cp = (r_tcnt >= L_FOUR) && (r_tcnt <= L_FIVE);
        w_sh = (r_tcnt >= L_SH_ON) && (r_tcnt <= L_SH_OFF);
        if (r_tcnt == L_SH_LAST) begin
          w_state_next = S_PIX;
          w_tcnt_next  = '0;
          w_slot_next  = '0;
        end else begin
          w_tcnt_next  = r_tcnt + 1'b1;
        end
      end
      S_PIX: begin
        w_p1   = (r_tcnt >= L_HALF);
        w_rs   = (r_tcnt >= L_TWO) && (r_tcnt <= L_THREE);
        w_cp   = (r_tcnt >= L_FOUR) && (r_tcnt <= L_FIVE);
        w_cs   = (r_tcnt < L_CS);
        w_sclk = (r_tcnt >= L_CS) && (r_tcnt < L_SCLK_END) && !w_sclk_off[0];
        if (r_tcnt == L_SLOT_LAST) begin
          w_tcnt_next = '0;
          w_word      = (r_slot != 14'd0);
          if (r_slot == L_NPIX) begin
            w_end        = 1'b1;
            w_state_next = (i_continuous && i_en) ? S_RESTART : S_IDLE;
          end else begin
            w_slot_next  = r_slot + 14'd1;
          end
        end else begin
          w_tcnt_next = r_tcnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The tick that leaves an sclk-high state is the one that drops sclk, so
  // sampling while w_sclk is high captures the bit on the falling edge.
  always_ff @(posedge i_clk_160M or negedge i_nrst) begin
    if (!i_nrst) begin
      r_shift      <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_index  <= '0;
      r_line_start <= 1'b0;
      r_line_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pix_valid  <= 1'b0;
      r_line_start <= 1'b0;
      r_line_done  <= 1'b0;
      if (w_tick) begin
        r_line_start <= w_start;
        r_line_done  <= w_end;
        if (w_start)
          r_busy <= 1'b1;
        else if (w_end && (w_state_next == S_IDLE))
          r_busy <= 1'b0;
        if (w_sclk)
          r_shift <= ADC_BITS'({r_shift, i_adc_sdo});
        if (w_word) begin
          r_pix_data  <= r_shift;
          r_pix_index <= w_idx;
          r_pix_valid <= i_cal_mode || w_in_win;
        end
      end
    end
  end

  assign o_ccd_p1     = w_p1;
  assign o_ccd_p2     = ~w_p1;
  assign o_ccd_sh     = w_sh;
  assign o_ccd_rs     = w_rs;
  assign o_ccd_cp     = w_cp;
  assign o_adc_cs     = w_cs;
  assign o_adc_sclk   = w_sclk;
  assign o_pix_valid  = r_pix_valid;
  assign o_pix_data   = r_pix_data;
  assign o_pix_index  = r_pix_index;
  assign o_line_start = r_line_start;
  assign o_line_done  = r_line_done;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_ccd_line_sequencer.sv
`timescale 1ns/1ps
module tb_ccd_line_sequencer;

  localparam int ADC = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic        continuous = 1'b0;
  logic        cal_mode = 1'b0;
  logic [7:0]  div = 8'd0;
  logic        adc_sdo = 1'b0;

  logic        o_ccd_p1, o_ccd_p2, o_ccd_sh, o_ccd_rs, o_ccd_cp;
  logic        o_adc_cs, o_adc_sclk;
  logic        o_pix_valid, o_line_start, o_line_done, o_busy;
  logic [15:0] o_pix_data;
  logic [13:0] o_pix_index;

  ccd_line_sequencer #(
    .N_PIX(8), .ADC_BITS(ADC), .SLOT_TICKS(48), .CS_TICKS(8), .SH_TICKS(80),
    .VALID_FIRST(2), .VALID_LAST(5), .DIV_W(8)
  ) dut (
    .i_clk_160M(clk), .i_nrst(nrst), .i_en(en), .i_continuous(continuous),
    .i_cal_mode(cal_mode), .i_div(div),
    .o_ccd_p1(o_ccd_p1), .o_ccd_p2(o_ccd_p2), .o_ccd_sh(o_ccd_sh),
    .o_ccd_rs(o_ccd_rs), .o_ccd_cp(o_ccd_cp),
    .o_adc_cs(o_adc_cs), .o_adc_sclk(o_adc_sclk), .i_adc_sdo(adc_sdo),
    .o_pix_valid(o_pix_valid), .o_pix_data(o_pix_data), .o_pix_index(o_pix_index),
    .o_line_start(o_line_start), .o_line_done(o_line_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected reset/idle vector: p1=1, everything else 0
  localparam logic [40:0] EXP_RST = {1'b1, 10'b0, 16'h0000, 14'h0000};

  function automatic logic [40:0] out_vec();
    return {o_ccd_p1, o_ccd_p2, o_ccd_sh, o_ccd_rs, o_ccd_cp, o_adc_cs, o_adc_sclk,
            o_pix_valid, o_line_start, o_line_done, o_busy, o_pix_data, o_pix_index};
  endfunction

  // ---------------- event monitor ----------------
  int   start_cnt = 0, done_cnt = 0, sh_cnt = 0, sclk_rise = 0;
  int   overlap = 0, busy_drop = 0, p2_bad = 0;
  logic prev_sclk = 1'b0;
  logic busy_watch = 1'b0;
  int   watch_until = 0;

  always @(negedge clk) begin
    if (busy_watch && done_cnt < watch_until && !o_busy && !o_line_done)
      busy_drop <= busy_drop + 1;
    if (o_line_start) start_cnt <= start_cnt + 1;
    if (o_line_done)  done_cnt  <= done_cnt + 1;
    if (o_ccd_sh)     sh_cnt    <= sh_cnt + 1;
    if (o_adc_sclk && !prev_sclk) sclk_rise <= sclk_rise + 1;
    if (o_adc_sclk && o_adc_cs)   overlap   <= overlap + 1;
    if (o_ccd_p2 !== ~o_ccd_p1)   p2_bad    <= p2_bad + 1;
    prev_sclk <= o_adc_sclk;
  end

  // ---------------- ADC model ----------------
  // Conversion n of a line returns tab[n]; MSB presented when cs falls, next
  // bit after each sclk falling edge.
  logic [15:0] tab [0:8];
  logic [15:0] adc_word = 16'h0;
  int          bit_i = 0, conv_idx = 0, seen_start = 0;
  logic        m_prev_cs = 1'b0, m_prev_sclk = 1'b0;

  always @(o_adc_cs, o_adc_sclk) begin
    if (m_prev_cs && !o_adc_cs) begin
      if (seen_start != start_cnt) begin
        conv_idx   = 0;
        seen_start = start_cnt;
      end
      adc_word = tab[(conv_idx > 8) ? 8 : conv_idx];
      conv_idx = conv_idx + 1;
      bit_i    = ADC - 1;
      adc_sdo  = adc_word[bit_i];
    end else if (m_prev_sclk && !o_adc_sclk && bit_i > 0) begin
      bit_i   = bit_i - 1;
      adc_sdo = adc_word[bit_i];
    end
    m_prev_cs   = o_adc_cs;
    m_prev_sclk = o_adc_sclk;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] d;
    logic [13:0] i;
  } exp_t;
  exp_t sb_q [$];

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_sig(input int sel, input int budget, input string name, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((sel == 0 && o_line_start) || (sel == 1 && o_line_done)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no pulse within %0d clks, required one", name, budget);
    end
  endtask

  task automatic run_line(input string name, input int len_exp);
    int t_s, t_d, sh0, sc0;
    sh0 = sh_cnt;
    sc0 = sclk_rise;
    en = 1'b1;
    wait_sig(0, 50, {name, "_start"}, t_s);
    en = 1'b0;
    wait_sig(1, 2000, {name, "_done"}, t_d);
    check({name, "_len"}, 64'(t_d - t_s), 64'(len_exp));
    check({name, "_sclk_pulses"}, 64'(sclk_rise - sc0), 64'd144);
    if (div == 8'd0) check({name, "_sh_ticks"}, 64'(sh_cnt - sh0), 64'd40);
    @(negedge clk);
    check({name, "_busy_low"}, 64'(o_busy), 64'd0);
    check({name, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp4 [0:7];
  int s1, d1, s2, d2, dc0, sc_before;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (o_pix_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_extra: got pixel idx %0d data 0x%0h, required no pixel",
                     o_pix_index, o_pix_data);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_data", 64'(o_pix_data), 64'(e.d));
            check("sb_index", 64'(o_pix_index), 64'(e.i));
          end
        end
      end
    join_none

    foreach (tab[k]) tab[k] = 16'hA5C3;

    // reset
    repeat (3) @(negedge clk);
    check("reset_hold", 64'(out_vec()), 64'(EXP_RST));
    nrst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_after_release", 64'(out_vec()), 64'(EXP_RST));

    // single line, cal_mode, constant ADC word
    cal_mode = 1'b1;
    for (int i = 0; i < 8; i++) sb_q.push_back({16'hA5C3, 14'(i)});
    run_line("line_cal", 512);

    // valid window, varying ADC words
    cal_mode = 1'b0;
    tab = '{16'h0000, 16'h1234, 16'hFFFF, 16'h8001, 16'h5A5A,
            16'h0F0F, 16'h7FFE, 16'hC3C3, 16'h0001};
    sb_q.push_back({16'h8001, 14'd2});
    sb_q.push_back({16'h5A5A, 14'd3});
    sb_q.push_back({16'h0F0F, 14'd4});
    sb_q.push_back({16'h7FFE, 14'd5});
    run_line("line_win", 512);

    // divider + continuous, two lines back-to-back
    exp4 = '{16'h1234, 16'hFFFF, 16'h8001, 16'h5A5A, 16'h0F0F, 16'h7FFE, 16'hC3C3, 16'h0001};
    div = 8'd3;
    continuous = 1'b1;
    cal_mode = 1'b1;
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 8; i++) sb_q.push_back({exp4[i], 14'(i)});
    en = 1'b1;
    wait_sig(0, 50, "cont_start1", s1);
    watch_until = done_cnt + 2;
    busy_watch = 1'b1;
    wait_sig(1, 3000, "cont_done1", d1);
    check("cont_len1", 64'(d1 - s1), 64'd2048);
    wait_sig(0, 20, "cont_start2", s2);
    check("cont_restart_gap", 64'(s2 - d1), 64'd4);
    repeat (100) @(negedge clk);
    en = 1'b0;
    wait_sig(1, 3000, "cont_done2", d2);
    check("cont_len2", 64'(d2 - s2), 64'd2048);
    @(negedge clk);
    busy_watch = 1'b0;
    check("cont_busy_low", 64'(o_busy), 64'd0);
    check("cont_busy_no_drop", 64'(busy_drop), 64'd0);
    check("cont_sb_drained", 64'(sb_q.size()), 64'd0);
    sc_before = start_cnt;
    repeat (50) @(negedge clk);
    check("cont_no_third_line", 64'(start_cnt), 64'(sc_before));

    // reset in the middle of slot 4
    div = 8'd0;
    continuous = 1'b0;
    foreach (tab[k]) tab[k] = 16'hA5C3;
    for (int i = 0; i < 3; i++) sb_q.push_back({16'hA5C3, 14'(i)});
    dc0 = done_cnt;
    en = 1'b1;
    wait_sig(0, 50, "rst_line_start", s1);
    en = 1'b0;
    repeat (80 + 4 * 48 + 5) @(negedge clk);
    check("slot4_p1_low", 64'(o_ccd_p1), 64'd0);
    #2 nrst = 1'b0;
    #1 check("midline_reset", 64'(out_vec()), 64'(EXP_RST));
    repeat (3) @(negedge clk);
    check("midline_sb_drained", 64'(sb_q.size()), 64'd0);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    check("midline_no_done", 64'(done_cnt), 64'(dc0));
    for (int i = 0; i < 8; i++) sb_q.push_back({16'hA5C3, 14'(i)});
    run_line("line_after_rst", 512);

    check("sclk_cs_overlap", 64'(overlap), 64'd0);
    check("p2_complement", 64'(p2_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccd_line_sequencer.md
Name: ccd_line_sequencer

Overview:
- Parametrised successor of the linear-CCD timing generator. Produces CCD phase, transfer, reset and clamp clocks, and drives a serial ADC readout for each pixel.
- Delivers pixel words with index and valid strobes to the downstream line buffer.
- Runs in the single clk_160M domain using a tick-enable divider; no derived clocks.
- Adds parametrised pixel count, ADC width and slot timing, continuous-line mode, and line start/done handshake.

Parameters:
- N_PIX, 2088, pixels clocked out per line.
- ADC_BITS, 16, serial ADC word width, MSB first.
- SLOT_TICKS, 48, ticks per pixel slot; must be >= CS_TICKS+2*ADC_BITS+1.
- CS_TICKS, 8, ticks adc_cs is held high at slot start.
- SH_TICKS, 80, ticks in the transfer phase; must be a multiple of 4 and >= 16.
- VALID_FIRST, 32, first pixel index flagged valid in normal mode.
- VALID_LAST, 2079, last pixel index flagged valid in normal mode.
- DIV_W, 8, width of the divider input.

Ports:
- clk_160M  in  1  system clock.
- nrst  in  1  asynchronous, active-low reset.
- en  in  1  line request, level-sensitive.
- continuous  in  1  when 1, start the next line back-to-back while en=1.
- cal_mode  in  1  when 1, flag every pixel valid.
- div  in  DIV_W  tick period = div+1 clk_160M cycles.
- ccd_p1  out  1  CCD phase 1.
- ccd_p2  out  1  CCD phase 2, always ~ccd_p1.
- ccd_sh  out  1  transfer gate.
- ccd_rs  out  1  output reset.
- ccd_cp  out  1  clamp.
- adc_cs  out  1  ADC convert/select.
- adc_sclk  out  1  ADC serial clock.
- adc_sdo  in  1  ADC serial data.
- pix_valid  out  1  one-clk strobe; pix_data and pix_index valid.
- pix_data  out  ADC_BITS  pixel word.
- pix_index  out  14  pixel number 0..N_PIX-1.
- line_start  out  1  one-clk pulse on entering transfer phase.
- line_done  out  1  one-clk pulse at end of line.
- busy  out  1  high from transfer start to line end.

Behaviour:

Reset:
- nrst low immediately forces: ccd_p1=1, ccd_p2=0, and ccd_sh, ccd_rs, ccd_cp, adc_cs, adc_sclk, pix_valid, line_start, line_done, busy=0.
- pix_data=0, pix_index=0, divider count=0, state=IDLE.
- Applies mid-line too; no line_done is issued.

Tick generation:
- Internal counter increments each clk. When count >= div, tick=1 for one clk and the counter clears.
- div=0 gives a tick every clk. A div change takes effect at the next wrap.
- All CCD/ADC outputs and the state machine advance only on tick. pix_valid, line_start and line_done are single-clk pulses.

State machine:
- IDLE: p1=1; other CCD/ADC outputs 0. On a tick with en=1, go to XFER with t=0, pulse line_start, set busy=1.
- XFER (tick t=0..SH_TICKS-1): p1=1 throughout. rs=1 for t in [1,2]; cp=1 for t in [4,5]; sh=1 for t in [SH_TICKS/4, 3*SH_TICKS/4-1]. After t=SH_TICKS-1, go to PIX with slot p=0, s=0.
- PIX (slot p=0..N_PIX, tick s=0..SLOT_TICKS-1):
  - p1=0 for s < SLOT_TICKS/2, else 1. rs=1 for s in [2,3]; cp=1 for s in [4,5].
  - adc_cs=1 for s in [0, CS_TICKS-1].
  - For bit k=0..ADC_BITS-1: sclk=1 at s=CS_TICKS+2k; sclk=0 at s=CS_TICKS+2k+1, and on that same tick adc_sdo is shifted in (first sample becomes MSB).
- Pipelining: the conversion started in slot p is the pixel shifted in slot p-1. On the tick s=SLOT_TICKS-1 of slot p>=1:
  - pix_data = assembled word, pix_index = p-1.
  - pix_valid pulses if cal_mode=1, or if VALID_FIRST <= p-1 <= VALID_LAST.
  - Slot 0 produces no output. The line is N_PIX+1 slots.
- End of line: after slot N_PIX, pulse line_done in the same clk as the final pix_valid.
  - If continuous=1 and en=1: go directly to XFER, pulse line_start on the next tick.
  - Otherwise go to IDLE and set busy=0.
- en deasserted mid-line: the line completes normally.
- cal_mode and the VALID window are sampled per word. pix_data and pix_index hold their values between strobes.
- Line length = SH_TICKS + (N_PIX+1)*SLOT_TICKS ticks.

Test Plan:
- Reset: hold nrst=0 -> p1=1, p2=0, all other outputs 0; release with en=0 -> outputs unchanged after 100 clks.
- Single line (N_PIX=8, SLOT_TICKS=48, SH_TICKS=80, div=0): pulse en for one tick -> line_start, then line_done 80+9*48=512 clks later. Exactly 8 pix_valid with cal_mode=1, index 0..7. sh high for 40 ticks.
- ADC shift: ADC model returns 16'hA5C3 for every conversion -> every pix_data = 16'hA5C3. 16 sclk pulses per slot, sclk never high while cs high.
- Valid window (N_PIX=8, VALID_FIRST=2, VALID_LAST=5, cal_mode=0) -> pix_valid only for indices 2..5.
- Divider and continuous mode: div=3, continuous=1, en held high -> ticks every 4 clks. Two lines back-to-back with line_start on the tick after line_done; busy never drops between them.
- Reset mid-line: assert nrst at slot 4 -> outputs return to reset values immediately. No line_done; a new line starts cleanly after release.
